// File: rtl/spi_mem_ctrl_pkg.sv
// Shared types and constants for the memory responder and its SPI shifter.
package spi_mem_ctrl_pkg;

    typedef enum logic [1:0] {
        MEM_NOP   = 2'b00,
        MEM_READ  = 2'b01,
        MEM_WRITE = 2'b10
    } mem_ctrl_op_e;

    typedef enum logic {
        PC  = 1'b0,
        MAR = 1'b1
    } addr_sel_e;

    localparam logic [7:0] SPI_CMD_READ   = 8'h03;
    localparam logic [7:0] SPI_CMD_WRITE  = 8'h02;
    localparam int         SPI_ADDR_BITS  = 24;
    localparam int         SPI_FRAME_BITS = 40;

endpackage

// File: rtl/spi_mem_ctrl_shifter.sv
// 40-bit MSB-first SPI frame shifter, mode 0, two system clocks per bit.
// The read byte is assembled from MISO during the final eight bits only.
module spi_shifter
    import spi_mem_ctrl_pkg::*;
(
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      shift_en,
    input  logic                      capture_en,
    input  logic [SPI_FRAME_BITS-1:0] frame,
    input  logic                      spi_miso,
    output logic                      spi_sck,
    output logic                      spi_mosi,
    output logic [7:0]                rx_data,
    output logic                      last_bit
);

    localparam logic [5:0] BIT_LAST     = 6'd39;
    localparam logic [5:0] BIT_RX_FIRST = 6'd32;

    logic [SPI_FRAME_BITS-1:0] shift_reg;
    logic                      phase;
    logic [5:0]                bit_cnt;
    logic [7:0]                rx_reg;

    assign last_bit = shift_en && phase && (bit_cnt == BIT_LAST);

    always_ff @(posedge clock) begin
        if (!reset) begin
            shift_reg <= '0;
            phase     <= 1'b0;
            bit_cnt   <= '0;
            rx_reg    <= '0;
        end else if (start) begin
            shift_reg <= frame;
            phase     <= 1'b0;
            bit_cnt   <= '0;
            rx_reg    <= '0;
        end else if (shift_en) begin
            if (!phase) begin
                phase <= 1'b1;
            end else begin
                // Falling SCK: advance MOSI and sample MISO held stable over the high phase.
                phase     <= 1'b0;
                shift_reg <= {shift_reg[SPI_FRAME_BITS-2:0], 1'b0};
                if (capture_en && (bit_cnt >= BIT_RX_FIRST))
                    rx_reg <= {rx_reg[6:0], spi_miso};
                bit_cnt <= (bit_cnt == BIT_LAST) ? 6'd0 : bit_cnt + 6'd1;
            end
        end
    end

    assign spi_sck  = phase;
    assign spi_mosi = shift_reg[SPI_FRAME_BITS-1];
    assign rx_data  = rx_reg;

endmodule

// File: rtl/spi_mem_ctrl.sv
// Memory responder: turns control-unit read/write requests into one SPI
// transaction on flash (PC) or RAM (MAR) and pulses mem_op_done on completion.
//
// state      | meaning
// IDLE       | sampling mem_ctrl_op each cycle
// SHIFT      | selected CS low, 40-bit frame on the wire
// CS_RELEASE | both CS high, read byte copied to data_out
// DONE       | one-cycle mem_op_done, request ignored
module spi_mem_ctrl
    import spi_mem_ctrl_pkg::*;
#(
    parameter int DATA_BUS_WIDTH = 8,
    parameter int ADDR_WIDTH     = 16
) (
    input  logic                      clock,
    input  logic                      reset,
    input  mem_ctrl_op_e              mem_ctrl_op,
    input  addr_sel_e                 addr_sel,
    input  logic [ADDR_WIDTH-1:0]     mem_addr,
    input  logic [DATA_BUS_WIDTH-1:0] data_in,
    output logic [DATA_BUS_WIDTH-1:0] data_out,
    output logic                      mem_op_done,
    output logic                      spi_sck,
    output logic                      spi_mosi,
    input  logic                      spi_miso,
    output logic                      spi_cs_flash_n,
    output logic                      spi_cs_ram_n
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        SHIFT      = 2'd1,
        CS_RELEASE = 2'd2,
        DONE       = 2'd3
    } state_e;

    state_e                    state, state_nxt;
    logic                      start;
    logic                      is_read;
    logic                      last_bit;
    logic [7:0]                rx_data;
    logic [SPI_FRAME_BITS-1:0] frame;

    assign frame = (mem_ctrl_op == MEM_READ)
                 ? {SPI_CMD_READ,  SPI_ADDR_BITS'(mem_addr), 8'h00}
                 : {SPI_CMD_WRITE, SPI_ADDR_BITS'(mem_addr), data_in};

    always_ff @(posedge clock) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        case (state)
            IDLE: begin
                case (mem_ctrl_op)
                    MEM_READ: begin
                        start     = 1'b1;
                        state_nxt = SHIFT;
                    end
                    MEM_WRITE: begin
                        // Flash is read-only here: acknowledge without touching the bus.
                        if (addr_sel == MAR) begin
                            start     = 1'b1;
                            state_nxt = SHIFT;
                        end else begin
                            state_nxt = DONE;
                        end
                    end
                    default: state_nxt = IDLE;
                endcase
            end
            SHIFT:      if (last_bit) state_nxt = CS_RELEASE;
            CS_RELEASE: state_nxt = DONE;
            DONE:       state_nxt = IDLE;
            default:    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            is_read        <= 1'b0;
            spi_cs_flash_n <= 1'b1;
            spi_cs_ram_n   <= 1'b1;
            data_out       <= '0;
        end else begin
            if (start) begin
                is_read        <= (mem_ctrl_op == MEM_READ);
                spi_cs_flash_n <= (addr_sel != PC);
                spi_cs_ram_n   <= (addr_sel != MAR);
            end else if (last_bit) begin
                spi_cs_flash_n <= 1'b1;
                spi_cs_ram_n   <= 1'b1;
            end
            if ((state == CS_RELEASE) && is_read)
                data_out <= rx_data;
        end
    end

    assign mem_op_done = (state == DONE);

    spi_shifter u_shifter (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .shift_en   (state == SHIFT),
        .capture_en (is_read),
        .frame      (frame),
        .spi_miso   (spi_miso),
        .spi_sck    (spi_sck),
        .spi_mosi   (spi_mosi),
        .rx_data    (rx_data),
        .last_bit   (last_bit)
    );

endmodule

// File: doc/spi_mem_ctrl.md
# spi_mem_ctrl

Memory responder that serves the control unit's `mem_ctrl_op` / `addr_sel` requests and answers with `mem_op_done`. Each accepted request is turned into one SPI transaction on a shared bus with two chip selects: program flash when `addr_sel == PC`, data RAM when `addr_sel == MAR`. Read data is returned on `data_out`, which the top level routes to the bus mux `MUX_MEM` input. It sits between the control/address-register datapath and the off-chip SPI devices.

## Interface
- `DATA_BUS_WIDTH`, default 8: data word width; fixed at 8 in this revision.
- `ADDR_WIDTH`, default 16: width of `mem_addr`. It is zero-extended to the 24-bit SPI address.
- `clock`  in  1  system clock.
- `reset`  in  1  reset, synchronous, active-low.
- `mem_ctrl_op`  in  `mem_ctrl_op_e`  request: `MEM_NOP`, `MEM_READ` or `MEM_WRITE`. Held by the requester until `mem_op_done`.
- `addr_sel`  in  `addr_sel_e`  target select: `PC` means flash, `MAR` means RAM.
- `mem_addr`  in  `ADDR_WIDTH`  address already selected by the address-register block.
- `data_in`  in  `DATA_BUS_WIDTH`  write data (ALU `THR` output).
- `data_out`  out  `DATA_BUS_WIDTH`  last read byte.
- `mem_op_done`  out  1  one-cycle completion pulse.
- `spi_sck`  out  1  SPI clock, mode 0.
- `spi_mosi`  out  1  serial data out, MSB first.
- `spi_miso`  in  1  serial data in.
- `spi_cs_flash_n`  out  1  flash chip select, active low.
- `spi_cs_ram_n`  out  1  RAM chip select, active low.

## Operation
- **States:** `IDLE`, `SHIFT`, `CS_RELEASE`, `DONE`.
- **IDLE:** samples `mem_ctrl_op` every cycle.
  - `MEM_READ`: latch target from `addr_sel`, latch `mem_addr`, and load frame `{cmd 0x03, 24'(mem_addr), 8'h00}`.
  - `MEM_WRITE` with `addr_sel == MAR`: latch `data_in` and load frame `{cmd 0x02, 24'(mem_addr), data_in}`.
  - `MEM_WRITE` with `addr_sel == PC` (flash write): unsupported. Go straight to `DONE` with no SPI activity; `data_out` is unchanged.
  - `MEM_NOP`: stay in `IDLE`.
- **SHIFT:** the selected CS is low; the other CS stays high.
  - 40 bits, MSB first, 2 clocks per bit: phase 0 has SCK low and MOSI updated; phase 1 has SCK high.
  - MISO is captured into a receive shift register at the end of each phase-1 cycle, for the last 8 bits only, and only on reads.
  - A 6-bit bit counter runs 0..39. On bit 39 phase 1, go to `CS_RELEASE`.
- **CS_RELEASE:** both CS high, SCK low. On reads, the receive register is copied to `data_out`. Go to `DONE`.
- **DONE:** `mem_op_done = 1` for exactly one cycle, then `IDLE`. `mem_ctrl_op` is ignored in `DONE`, because the requester's registered op still shows the old request in that cycle.
- After acceptance, changes to `mem_ctrl_op`, `addr_sel`, `mem_addr` and `data_in` are ignored until `DONE`.
- An unknown `mem_ctrl_op` encoding is treated as `MEM_NOP`.
- SPI address wraps only through zero-extension; there is no arithmetic on the address.

## Timing
- **Reset values (all outputs):** state `IDLE`; `mem_op_done` 0; `data_out` 0; `spi_sck` 0; `spi_mosi` 0; both CS 1. All internal shift registers and counters are 0.
- **Reset mid-transaction:** the transaction aborts on the same edge. CS deasserts with no done pulse and `data_out` is not updated.
- **SPI latency:** request sampled in `IDLE` at cycle t0 → CS low from t0+1 → 80 shift cycles (t0+1..t0+80) → `CS_RELEASE` at t0+81 → `mem_op_done` at t0+82.
- **Flash-write latency:** sampled at t0 → done at t0+1.
- **data_out validity:** valid from the `mem_op_done` cycle and held until the next completed read.
- **Back-to-back requests:** a new request presented in the cycle after `DONE` is sampled immediately, so the minimum gap between transactions is 1 `IDLE` cycle.
- **Registered outputs:** `spi_sck`, `spi_mosi` and both CS are driven directly from flops, with no combinational path from inputs.

## Structure
- **Shared package:** `mem_ctrl_op_e` and `addr_sel_e` stay there. Add `SPI_CMD_READ = 8'h03`, `SPI_CMD_WRITE = 8'h02` and `SPI_ADDR_BITS = 24`.
- **Local state enum:** the FSM enum is local to this module.
- **Sub-module:** `spi_shifter`, a 40-bit parallel-load MSB-first shift register with MOSI out, an 8-bit MISO capture register, the phase toggle and the bit counter. It takes a `start` input and produces a `last_bit` output. The FSM and chip-select decode stay in the top module.

## Test plan
- **Reset:** hold `reset=0` for 3 cycles while `MEM_READ` is presented → both CS 1, `mem_op_done` 0, `data_out` 0; no SCK edges.
- **Flash read:** `MEM_READ`, `addr_sel=PC`, `mem_addr=16'h1234`, MISO model returns 8'hA5 → `spi_cs_flash_n` low for 80 cycles; MOSI carries `03 00 12 34`; `data_out=8'hA5` and done pulse at t0+82; `spi_cs_ram_n` stays 1.
- **RAM write:** `MEM_WRITE`, `addr_sel=MAR`, `mem_addr=16'h00FF`, `data_in=8'h3C` → RAM CS low; MOSI carries `02 00 00 FF 3C`; done at t0+82; `data_out` unchanged.
- **Flash write:** `MEM_WRITE`, `addr_sel=PC` → no CS activity; done at t0+1.
- **Back-to-back:** RAM read completes, then `MEM_WRITE` is presented the cycle after `DONE` → second transaction's CS goes low 2 cycles after the first done pulse; requester op changes mid-transaction are ignored.
- **Reset mid-transaction:** `reset=0` at bit 20 of a read → next cycle CS high, SCK 0; no done pulse; `data_out` keeps its prior value.
